motor_step_gen: RTL
===================

# motor_step_gen

Step/direction pulse generator for the bend-motor driver. It sits directly downstream of the FSMC register file. It takes a move command (operation, direction, step count, step period) assembled from bytes the STM32 writes over FSMC, moves it safely into the CLK domain, and emits a timed STEP/DIR pulse train with busy/done/error status and a live step count for readback.

## Interface
Parameters:
- SYNC_STAGES, 2, flops in the command-toggle synchronizer (≥2)
- PULSE_W, 50, STEP high time in CLK cycles (1 µs at 50 MHz)
- DIR_SETUP, 10, cycles DIR is held stable before the first STEP rise
- MIN_PERIOD, 100, smallest legal CMD_PERIOD; must be > PULSE_W

Ports:
- CLK  in  1  50 MHz system clock
- RST  in  1  reset, asynchronous, active-high
- CMD_TGL  in  1  FSMC-domain toggle; each level change means one new command
- CMD_OP  in  2  00 NOP, 01 START, 10 STOP, 11 ABORT
- CMD_DIR  in  1  direction for START
- CMD_STEPS  in  16  step count for START
- CMD_PERIOD  in  16  STEP rise-to-rise period in CLK cycles
- STEP  out  1  step pulse to driver
- DIR  out  1  direction to driver
- BUSY  out  1  move in progress (state ≠ IDLE)
- DONE  out  1  sticky; last move completed all steps
- ERR  out  1  sticky; last command rejected
- POS  out  16  steps issued in current or last move

## Operation
- CMD_* fields are stable from before the CMD_TGL change until ≥ SYNC_STAGES+3 cycles after it. Firmware guarantees this by writing the data bytes first and the toggle byte last.
- CMD_TGL passes through SYNC_STAGES flops, then one edge-detect flop. A level change produces a single-cycle cmd_evt. CMD_* are sampled on cmd_evt.
- States: IDLE, SETUP, HIGH, LOW.
- START in IDLE:
  - Legal (CMD_STEPS ≠ 0 and CMD_PERIOD ≥ MIN_PERIOD): latch the fields, DIR←CMD_DIR, POS←0, DONE←0, ERR←0, go to SETUP.
  - Illegal: stay in IDLE, ERR←1, DONE, POS and DIR unchanged.
- START when not in IDLE: ignored, ERR←1, the move continues.
- SETUP: wait DIR_SETUP cycles → HIGH.
- HIGH: STEP=1. POS increments on entry. Stay PULSE_W cycles → LOW.
- LOW: STEP=0, stay CMD_PERIOD−PULSE_W cycles.
  - If POS == latched steps: go to IDLE, DONE←1.
  - Otherwise: go to HIGH.
- STOP:
  - In SETUP or LOW: go to IDLE next cycle.
  - In HIGH: finish the current high phase, then go to IDLE.
  - DONE stays 0. Ignored in IDLE.
- ABORT: IDLE next cycle from any state. STEP=0 the same cycle the state updates. DONE stays 0.
- NOP: no effect.
- DIR never changes while BUSY.
- Arithmetic: 16-bit unsigned counters, no wrap.
  - POS saturates naturally because it stops at CMD_STEPS ≤ 65535.
  - Phase counter loads PULSE_W−1 or CMD_PERIOD−PULSE_W−1 and counts down to 0.

## Timing
- Reset values: STEP=0, DIR=0, BUSY=0, DONE=0, ERR=0, POS=0, state IDLE, synchronizer flops 0.
- RST takes effect immediately (async), including mid-pulse; STEP falls without waiting for CLK.
- CMD_TGL change → cmd_evt asserted SYNC_STAGES+1 edges later (3 with defaults).
- START accepted on cmd_evt cycle T:
  - BUSY=1 and DIR valid from T+1.
  - First STEP rise at T+1+DIR_SETUP.
- STEP rise-to-rise is exactly CMD_PERIOD cycles; high time is exactly PULSE_W cycles.
- Last STEP falls at rise+PULSE_W. BUSY falls and DONE rises at last rise + CMD_PERIOD (the end of the final LOW phase).
- Outputs are registered; no combinational path from inputs to outputs.

## Structure
- Shared package motor_pkg:
  - opcode constants OP_NOP/OP_START/OP_STOP/OP_ABORT
  - state encoding type
  - 16-bit count typedef
- One sub-module: sync_toggle (SYNC_STAGES-deep synchronizer plus edge detect producing the one-cycle pulse). It is reused by later FSMC-fed blocks.

## Test plan
- START, DIR=1, STEPS=3, PERIOD=200 → DIR=1 at T+1, STEP rises at T+11, T+211, T+411, each 50 cycles high; DONE=1, BUSY=0 at T+611; POS=3.
- START with PERIOD=99 or STEPS=0 → ERR=1, BUSY stays 0, STEP never toggles; next legal START clears ERR.
- STOP cmd_evt 20 cycles into the second HIGH phase of STEPS=10 → high lasts the full 50 cycles, then IDLE; POS=2, DONE=0.
- ABORT mid-HIGH → STEP low and BUSY=0 one cycle later; POS keeps its value; DONE=0.
- START issued while BUSY → ERR=1, pulse train and POS unaffected, DONE=1 at the normal end time.
- RST asserted mid-HIGH between clock edges → STEP=0 immediately, all outputs at reset values; the toggle change seen after RST release yields exactly one cmd_evt.

Source files
------------

// File: rtl/motor_pkg.sv
// ============================================================================
// motor_pkg : opcodes, state encoding and count type shared by the step generator
// Revision  : 1.0
// ============================================================================
`default_nettype none

package motor_pkg;

   localparam logic [1:0] OP_NOP   = 2'b00;
   localparam logic [1:0] OP_START = 2'b01;
   localparam logic [1:0] OP_STOP  = 2'b10;
   localparam logic [1:0] OP_ABORT = 2'b11;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SETUP = 2'd1,
      ST_HIGH  = 2'd2,
      ST_LOW   = 2'd3
   } state_t;

   typedef logic [15:0] count_t;

   function automatic logic start_legal(input count_t steps,
                                        input count_t period,
                                        input count_t min_period);
      return (steps != '0) && (period >= min_period);
   endfunction

endpackage

`default_nettype wire

// File: rtl/sync_toggle.sv
// ============================================================================
// sync_toggle : multi-flop synchronizer for a toggle-encoded event, plus edge
//               detect producing a registered one-cycle pulse per level change
// Revision    : 1.0
// ============================================================================
`default_nettype none

module sync_toggle #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic i_tgl,
   output logic o_evt
);

   logic [SYNC_STAGES-1:0] sync_q, sync_d;
   logic                   last_q, last_d;
   logic                   evt_q,  evt_d;

   always_comb begin
      sync_d = {sync_q[SYNC_STAGES-2:0], i_tgl};
      last_d = sync_q[SYNC_STAGES-1];
      evt_d  = sync_q[SYNC_STAGES-1] ^ last_q;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync_q <= '0;
         last_q <= 1'b0;
         evt_q  <= 1'b0;
      end else begin
         sync_q <= sync_d;
         last_q <= last_d;
         evt_q  <= evt_d;
      end
   end

   assign o_evt = evt_q;

endmodule

`default_nettype wire

// File: rtl/motor_step_gen.sv
// ============================================================================
// motor_step_gen : STEP/DIR pulse generator fed by toggle-handshaked commands
// Revision       : 1.0
// ============================================================================
`default_nettype none

module motor_step_gen
   import motor_pkg::*;
#(
   parameter int SYNC_STAGES = 2,
   parameter int PULSE_W     = 50,
   parameter int DIR_SETUP   = 10,
   parameter int MIN_PERIOD  = 100
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic        CMD_TGL,
   input  logic [1:0]  CMD_OP,
   input  logic        CMD_DIR,
   input  logic [15:0] CMD_STEPS,
   input  logic [15:0] CMD_PERIOD,
   output logic        STEP,
   output logic        DIR,
   output logic        BUSY,
   output logic        DONE,
   output logic        ERR,
   output logic [15:0] POS
);

   localparam count_t C_PULSE_LOAD = count_t'(PULSE_W - 1);
   localparam count_t C_SETUP_LOAD = count_t'(DIR_SETUP - 1);
   localparam count_t C_LOW_BIAS   = count_t'(PULSE_W + 1);
   localparam count_t C_MIN_PERIOD = count_t'(MIN_PERIOD);

   logic cmd_evt;

   sync_toggle #(
      .SYNC_STAGES(SYNC_STAGES)
   ) u_sync (
      .clk  (CLK),
      .rst  (RST),
      .i_tgl(CMD_TGL),
      .o_evt(cmd_evt)
   );

   state_t state_q, state_d;
   count_t cnt_q,    cnt_d;
   count_t pos_q,    pos_d;
   count_t steps_q,  steps_d;
   count_t period_q, period_d;
   logic   step_q,   step_d;
   logic   dir_q,    dir_d;
   logic   busy_q,   busy_d;
   logic   done_q,   done_d;
   logic   err_q,    err_d;
   logic   stop_q,   stop_d;

   logic is_start, is_stop, is_abort;

   always_comb begin
      is_start = cmd_evt && (CMD_OP == OP_START);
      is_stop  = cmd_evt && (CMD_OP == OP_STOP);
      is_abort = cmd_evt && (CMD_OP == OP_ABORT);

      state_d  = state_q;
      cnt_d    = cnt_q;
      pos_d    = pos_q;
      steps_d  = steps_q;
      period_d = period_q;
      step_d   = step_q;
      dir_d    = dir_q;
      busy_d   = busy_q;
      done_d   = done_q;
      err_d    = err_q;
      stop_d   = stop_q;

      case (state_q)
         ST_IDLE: begin
            if (is_start) begin
               if (start_legal(CMD_STEPS, CMD_PERIOD, C_MIN_PERIOD)) begin
                  steps_d  = CMD_STEPS;
                  period_d = CMD_PERIOD;
                  dir_d    = CMD_DIR;
                  pos_d    = '0;
                  done_d   = 1'b0;
                  err_d    = 1'b0;
                  busy_d   = 1'b1;
                  stop_d   = 1'b0;
                  cnt_d    = C_SETUP_LOAD;
                  state_d  = ST_SETUP;
               end else begin
                  err_d = 1'b1;
               end
            end
         end

         ST_SETUP: begin
            if (is_abort || is_stop) begin
               state_d = ST_IDLE;
               busy_d  = 1'b0;
            end else if (cnt_q == '0) begin
               state_d = ST_HIGH;
               step_d  = 1'b1;
               pos_d   = pos_q + 16'd1;
               cnt_d   = C_PULSE_LOAD;
            end else begin
               cnt_d = cnt_q - 16'd1;
            end
         end

         ST_HIGH: begin
            // A STOP here only takes effect once the full high time has elapsed.
            if (is_abort) begin
               state_d = ST_IDLE;
               busy_d  = 1'b0;
               step_d  = 1'b0;
            end else if (cnt_q == '0) begin
               step_d = 1'b0;
               if (stop_q || is_stop) begin
                  state_d = ST_IDLE;
                  busy_d  = 1'b0;
               end else begin
                  state_d = ST_LOW;
                  cnt_d   = period_q - C_LOW_BIAS;
               end
            end else begin
               cnt_d = cnt_q - 16'd1;
               if (is_stop) begin
                  stop_d = 1'b1;
               end
            end
         end

         ST_LOW: begin
            if (is_abort || is_stop) begin
               state_d = ST_IDLE;
               busy_d  = 1'b0;
            end else if (cnt_q == '0) begin
               if (pos_q == steps_q) begin
                  state_d = ST_IDLE;
                  busy_d  = 1'b0;
                  done_d  = 1'b1;
               end else begin
                  state_d = ST_HIGH;
                  step_d  = 1'b1;
                  pos_d   = pos_q + 16'd1;
                  cnt_d   = C_PULSE_LOAD;
               end
            end else begin
               cnt_d = cnt_q - 16'd1;
            end
         end

         default: begin
            state_d = ST_IDLE;
            busy_d  = 1'b0;
            step_d  = 1'b0;
         end
      endcase

      if (is_start && (state_q != ST_IDLE)) begin
         err_d = 1'b1;
      end

      if (state_d == ST_IDLE) begin
         stop_d = 1'b0;
      end
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q  <= ST_IDLE;
         cnt_q    <= '0;
         pos_q    <= '0;
         steps_q  <= '0;
         period_q <= '0;
         step_q   <= 1'b0;
         dir_q    <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         err_q    <= 1'b0;
         stop_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         pos_q    <= pos_d;
         steps_q  <= steps_d;
         period_q <= period_d;
         step_q   <= step_d;
         dir_q    <= dir_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
         err_q    <= err_d;
         stop_q   <= stop_d;
      end
   end

   assign STEP = step_q;
   assign DIR  = dir_q;
   assign BUSY = busy_q;
   assign DONE = done_q;
   assign ERR  = err_q;
   assign POS  = pos_q;

endmodule

`default_nettype wire
